// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, state encoding and weight ROM layout for the
// time-multiplexed network sequencer and its MAC datapath.
package nn_pkg;

    localparam int N_IN     = 9;
    localparam int N_HID    = 4;
    localparam int IN_W     = 100;
    localparam int W_W      = 33;
    localparam int WA_W     = 6;
    localparam int OUT_BASE = N_HID * (N_IN + 1);

    typedef enum logic [2:0] {
        IDLE,
        MAC_H,
        ACT_H,
        MAC_O,
        ACT_O,
        DONE
    } state_t;

    // First ROM word of hidden neuron h (N_IN weights, then its bias).
    function automatic int hid_base(input int h);
        return h * (N_IN + 1);
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if: start/in_vec request, weight ROM port and
// busy/out_2/end_2 result. slave = sequencer, master = host + ROM.
interface nn_layer_sequencer_if;
    import nn_pkg::*;

    logic                   start;
    logic [N_IN*IN_W-1:0]   in_vec;
    logic [WA_W-1:0]        w_addr;
    logic [W_W-1:0]         w_data;
    logic                   busy;
    logic [IN_W-1:0]        out_2;
    logic                   end_2;

    modport master (
        output start, in_vec, w_data,
        input  w_addr, busy, out_2, end_2
    );

    modport slave (
        input  start, in_vec, w_data,
        output w_addr, busy, out_2, end_2
    );

endinterface

// File: rtl/nn_mac_unit.sv
// nn_mac_unit: two-stage multiply-accumulate matching a 1-cycle ROM.
// Ports: clr/en/bias_sel/opnd issued with the address, w_data, acc, acc_nxt.
module nn_mac_unit
    import nn_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic            bias_sel,
    input  logic [IN_W-1:0] opnd,
    input  logic [W_W-1:0]  w_data,
    output logic [IN_W-1:0] acc,
    output logic [IN_W-1:0] acc_nxt
);

    // Stage 1 rides along with w_addr, stage 2 lines up with w_data.
    logic            v1, v2;
    logic [IN_W-1:0] op1, op2;
    logic [IN_W-1:0] w_ext, prod;

    // Low IN_W bits of the sign-extended product: truncating wrap.
    assign w_ext = {{(IN_W-W_W){w_data[W_W-1]}}, w_data};
    assign prod  = op2 * w_ext;

    always_comb begin
        acc_nxt = acc;
        if (clr)
            acc_nxt = '0;
        else if (v2)
            acc_nxt = acc + prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            op1 <= '0;
            op2 <= '0;
            acc <= '0;
        end else begin
            v1  <= en;
            op1 <= bias_sel ? IN_W'(1) : opnd;
            v2  <= v1;
            op2 <= op1;
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: runs N_HID ReLU neurons then one step neuron on a
// shared MAC. Ports: clk, rst, bus (start/in_vec/w_addr/w_data/busy/out_2/end_2).
module nn_layer_sequencer
    import nn_pkg::*;
(
    input logic                clk,
    input logic                rst,
    nn_layer_sequencer_if.slave bus
);

    localparam int KW = $clog2(N_IN + 3);
    localparam int HB = $clog2(N_HID);
    localparam int IB = $clog2(N_IN);

    localparam logic [KW-1:0] K_BIAS_H = KW'(N_IN);
    localparam logic [KW-1:0] K_END_H  = KW'(N_IN + 2);
    localparam logic [KW-1:0] K_BIAS_O = KW'(N_HID);
    localparam logic [KW-1:0] K_END_O  = KW'(N_HID + 2);
    localparam logic [HB-1:0] H_LAST   = HB'(N_HID - 1);

    state_t          state, nxt;
    logic [KW-1:0]   k;
    logic [HB-1:0]   h;
    logic [IN_W-1:0] in_buf [N_IN];
    logic [IN_W-1:0] hid [N_HID];
    logic [WA_W-1:0] w_addr_q;
    logic [IN_W-1:0] out_q;
    logic            end_q;

    logic [IN_W-1:0] acc, acc_nxt, relu;
    logic            nxt_pos;
    logic            iss, iss_bias, mac_clr;
    logic [WA_W-1:0] iss_addr;
    logic [IN_W-1:0] iss_op;

    nn_mac_unit u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr),
        .en       (iss),
        .bias_sel (iss_bias),
        .opnd     (iss_op),
        .w_data   (bus.w_data),
        .acc      (acc),
        .acc_nxt  (acc_nxt)
    );

    assign relu    = (!acc[IN_W-1] && acc != '0) ? acc : '0;
    assign nxt_pos = !acc_nxt[IN_W-1] && acc_nxt != '0;

    assign bus.w_addr = w_addr_q;
    assign bus.out_2  = out_q;
    assign bus.end_2  = end_q;
    assign bus.busy   = (state == MAC_H) || (state == ACT_H)
                     || (state == MAC_O);

    // k is the index of the fetch issued this cycle; two drain cycles
    // follow the bias. The ACT_H cycle issues fetch 0 of the next
    // neuron, so only the first neuron pays the extra setup cycle.
    always_comb begin
        nxt      = state;
        iss      = 1'b0;
        iss_bias = 1'b0;
        iss_addr = w_addr_q;
        iss_op   = '0;
        mac_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    nxt     = MAC_H;
                    mac_clr = 1'b1;
                end
            end
            MAC_H: begin
                if (k <= K_BIAS_H) begin
                    iss      = 1'b1;
                    iss_addr = WA_W'(hid_base(int'(h)) + int'(k));
                    iss_bias = (k == K_BIAS_H);
                    if (k < K_BIAS_H)
                        iss_op = in_buf[k[IB-1:0]];
                end
                if (k == K_END_H)
                    nxt = ACT_H;
            end
            ACT_H: begin
                mac_clr = 1'b1;
                iss     = 1'b1;
                if (h == H_LAST) begin
                    nxt      = MAC_O;
                    iss_addr = WA_W'(OUT_BASE);
                    // hid[h] is written this edge; only matters if N_HID==1
                    iss_op   = (h == '0) ? relu : hid[0];
                end else begin
                    nxt      = MAC_H;
                    iss_addr = WA_W'(hid_base(int'(h) + 1));
                    iss_op   = in_buf[0];
                end
            end
            MAC_O: begin
                if (k <= K_BIAS_O) begin
                    iss      = 1'b1;
                    iss_addr = WA_W'(OUT_BASE + int'(k));
                    iss_bias = (k == K_BIAS_O);
                    if (k < K_BIAS_O)
                        iss_op = hid[k[HB-1:0]];
                end
                if (k == K_END_O)
                    nxt = ACT_O;
            end
            ACT_O:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            h        <= '0;
            w_addr_q <= '0;
            out_q    <= '0;
            end_q    <= 1'b0;
            for (int i = 0; i < N_IN; i++)
                in_buf[i] <= '0;
            for (int i = 0; i < N_HID; i++)
                hid[i] <= '0;
        end else begin
            state <= nxt;
            end_q <= 1'b0;
            if (iss)
                w_addr_q <= iss_addr;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < N_IN; i++)
                            in_buf[i] <= bus.in_vec[i*IN_W +: IN_W];
                        k <= '0;
                        h <= '0;
                    end
                end
                MAC_H: k <= k + 1'b1;
                MAC_O: begin
                    k <= k + 1'b1;
                    // Last drain edge: result lands with end_2 in ACT_O.
                    if (k == K_END_O) begin
                        out_q <= {{(IN_W-1){1'b0}}, nxt_pos};
                        end_q <= 1'b1;
                    end
                end
                ACT_H: begin
                    hid[h] <= relu;
                    k      <= KW'(1);
                    if (h != H_LAST)
                        h <= h + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
